// File: rtl/uart_pkg.sv
// Shared serial-link definitions: receiver FSM states and default framing constants
// used by both ends of the board serial link.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 434;
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit; both flops reset to
// RESET_VAL so an idle-high line does not look like a start bit after reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deframer.sv
// 8N1 serial receiver: synchronises io_rx, deframes start/data/stop bits and
// presents each byte in a one-entry valid/ready holding register.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic                 rx_s;
  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 shift_en;
  logic                 stop_good;
  logic                 stop_bad;
  logic                 accept;
  logic                 commit_ok;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (io_rx),
    .q     (rx_s)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Each sampling state counts down to zero and samples rx_s at mid-bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_en  = 1'b0;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = CNT_HALF;
        end
      end
      START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (rx_s) begin
          state_d = IDLE;
        end else begin
          state_d = DATA;
          cnt_d   = CNT_FULL;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          shift_en = 1'b1;
          cnt_d    = CNT_FULL;
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (rx_s) begin
          stop_good = 1'b1;
          state_d   = IDLE;
        end else begin
          stop_bad = 1'b1;
          state_d  = BREAK;
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Data bits arrive LSB first, so shift in from the top.
  always_ff @(posedge clock) begin
    if (shift_en) begin
      shreg_q <= {rx_s, shreg_q[DATA_BITS-1:1]};
    end
  end

  assign accept    = rx_valid && rx_ready;
  assign commit_ok = stop_good && (!rx_valid || rx_ready);

  // A byte arriving while the holding register is full and not being drained is dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_frame_err <= stop_bad;
      rx_overrun   <= stop_good && !commit_ok;
      if (commit_ok) begin
        rx_data  <= shreg_q;
        rx_valid <= 1'b1;
      end else if (accept) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer at 16 clocks per bit.
module tb_uart_rx_deframer;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic       clock;
  logic       reset;
  logic       io_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_frame_err;
  logic       rx_overrun;

  int n_vec = 0;
  int n_err = 0;
  int n_rise = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  logic valid_prev = 1'b0;
  logic [7:0] xq[$];

  uart_rx_deframer #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .io_rx        (io_rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (rx_valid && !valid_prev) n_rise++;
    valid_prev = rx_valid;
    if (rx_frame_err) n_ferr++;
    if (rx_overrun) n_ovr++;
    if (rx_valid && rx_ready) xq.push_back(rx_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      io_rx = bits[i];
      repeat (CPB) @(posedge clock);
      #1;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    io_rx    = 1'b1;
    rx_ready = 1'b1;
    cycles(3);
    check("reset_valid", 32'(rx_valid), 32'h0);
    check("reset_data", 32'(rx_data), 32'h0);
    check("reset_ferr", 32'(rx_frame_err), 32'h0);
    check("reset_ovr", 32'(rx_overrun), 32'h0);
    check("reset_state", 32'(dut.state_q), 32'(IDLE));
    reset = 1'b1;
    cycles(5);

    // 1: good frame 0x55
    send_frame(8'h55, 1'b1);
    cycles(20);
    check("t1_rise", 32'(n_rise), 32'd1);
    check("t1_xfers", 32'(xq.size()), 32'd1);
    check("t1_data", 32'(xq[0]), 32'h55);
    check("t1_ferr", 32'(n_ferr), 32'd0);
    check("t1_ovr", 32'(n_ovr), 32'd0);

    // 2: short glitch rejected
    io_rx = 1'b0;
    cycles(5);
    io_rx = 1'b1;
    cycles(40);
    check("t2_rise", 32'(n_rise), 32'd1);
    check("t2_ferr", 32'(n_ferr), 32'd0);
    check("t2_state", 32'(dut.state_q), 32'(IDLE));

    // 3: bad stop then break, then recovery
    send_frame(8'hA3, 1'b0);
    cycles(200);
    io_rx = 1'b1;
    cycles(40);
    check("t3_ferr", 32'(n_ferr), 32'd1);
    check("t3_rise", 32'(n_rise), 32'd1);
    send_frame(8'h3C, 1'b1);
    cycles(20);
    check("t3_xfers", 32'(xq.size()), 32'd2);
    check("t3_data", 32'(xq[1]), 32'h3C);
    check("t3_ferr_after", 32'(n_ferr), 32'd1);

    // 4: overrun while holding register is full
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    cycles(4);
    check("t4_valid", 32'(rx_valid), 32'h1);
    check("t4_data", 32'(rx_data), 32'h11);
    send_frame(8'h22, 1'b1);
    cycles(4);
    check("t4_ovr", 32'(n_ovr), 32'd1);
    check("t4_data_kept", 32'(rx_data), 32'h11);
    check("t4_valid_kept", 32'(rx_valid), 32'h1);
    rx_ready = 1'b1;
    cycles(1);
    rx_ready = 1'b0;
    check("t4_valid_fall", 32'(rx_valid), 32'h0);
    cycles(2);
    check("t4_xfers", 32'(xq.size()), 32'd3);
    check("t4_pop", 32'(xq[2]), 32'h11);

    // 5: back-to-back frames, ready pulsed on the second commit cycle
    fork
      begin
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
      end
      begin
        repeat (314) @(posedge clock);
        #1 rx_ready = 1'b1;
        @(posedge clock);
        #1 rx_ready = 1'b0;
      end
    join
    cycles(4);
    check("t5_xfers", 32'(xq.size()), 32'd4);
    check("t5_first", 32'(xq[3]), 32'h00);
    check("t5_data", 32'(rx_data), 32'hFF);
    check("t5_valid", 32'(rx_valid), 32'h1);
    check("t5_ovr", 32'(n_ovr), 32'd1);

    // 6: reset mid-frame, then a clean frame
    fork
      send_frame(8'h7E, 1'b1);
      begin
        repeat (60) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        check("t6_valid", 32'(rx_valid), 32'h0);
        check("t6_data", 32'(rx_data), 32'h0);
        check("t6_state", 32'(dut.state_q), 32'(IDLE));
      end
    join
    cycles(5);
    reset = 1'b1;
    cycles(10);
    rx_ready = 1'b1;
    send_frame(8'hC9, 1'b1);
    cycles(20);
    check("t6_xfers", 32'(xq.size()), 32'd5);
    check("t6_data_after", 32'(xq[4]), 32'hC9);
    check("t6_ferr", 32'(n_ferr), 32'd1);
    check("t6_ovr", 32'(n_ovr), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
